rom_rr_arbiter: RTL and testbench
=================================

Name: rom_rr_arbiter

Overview:
Round-robin arbiter that shares one sync_rom instance (1-cycle registered read) between NREQ requesters. Each requester issues address requests with a valid/ready handshake and receives a one-hot-tagged response exactly one cycle after acceptance. The arbiter drives the ROM address port and forwards ROM data. It sits between client engines (table lookups, microcode fetch) and the shared ROM.

Parameters:
NREQ, 4, number of requesters (2..16)
DEPTH, 8, ROM depth, must match attached sync_rom
WIDTH, 8, ROM data width, must match attached sync_rom
AW (localparam), $clog2(DEPTH), address width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  arbitration enable; 0 = no new grants
req_valid  in  NREQ  per-requester request valid
req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
req_ready  out  NREQ  one-hot accept, combinational
rom_addr  out  AW  to sync_rom addr
rom_dout  in  WIDTH  from sync_rom dout
rsp_valid  out  NREQ  one-hot response valid, registered
rsp_data  out  WIDTH  response data, equals rom_dout
grant_cnt  out  16  total accepted requests, wraps at 0xFFFF->0

Behaviour:
- Reset (async assert, sync deassert by the system): rsp_valid=0, grant_cnt=0, priority pointer ptr=NREQ-1, so requester 0 has highest priority first. req_ready is 0 whenever en=0 or no req_valid is set.
- Arbitration (combinational): search order ptr+1, ptr+2, ... wrapping modulo NREQ. First i with req_valid[i]=1 is granted; req_ready[i]=1 only when en=1. At most one req_ready bit high.
- Transfer occurs on an edge where req_valid[i] & req_ready[i]. Same edge: ROM samples rom_addr; ptr <= i; grant_cnt++; rsp_valid <= one-hot(i).
- rom_addr = req_addr of granted requester. With no grant it holds the last granted address (registered copy) to avoid toggling; reset value 0.
- Latency: response exactly 1 cycle after acceptance; rsp_data = rom_dout is valid while rsp_valid != 0. No response backpressure; requesters must sink responses.
- Throughput: one grant per cycle, back-to-back; rsp_valid is continuously high across consecutive grants, with the tag changing per cycle.
- Fairness: with all requesters valid, grants rotate 0,1,2,...,NREQ-1,0; any continuously-valid requester is granted within NREQ cycles.
- A requester may drop req_valid without being granted, and may change its address while waiting; the value sampled at acceptance wins.
- en deasserted: no grants, ptr frozen. The in-flight response from the prior cycle still completes.
- Reset mid-operation: the in-flight response is discarded (rsp_valid forced 0 immediately), ptr returns to NREQ-1.
- Out-of-range address (DEPTH not a power of 2): passed through unchanged. The ROM behaviour defines the result, and the arbiter makes no check.

Decomposition:
- Shared package rom_arb_pkg: default NREQ/DEPTH/WIDTH constants and GRANT_CNT_W=16.
- One sub-module, rr_pick: combinational round-robin picker (inputs req vector and ptr; outputs one-hot grant and index, plus any). Keeps rotate/priority logic separately testable.
- The ROM is not instantiated inside the arbiter. The top-level connects rom_addr/rom_dout to sync_rom.

Test Plan:
- Reset then single request: req_valid=0001, addr0=2 -> req_ready=0001 same cycle; next cycle rsp_valid=0001, rsp_data=0xC2; grant_cnt=1.
- All four valid, addrs 0,1,2,3, held 4 cycles -> grants 0,1,2,3 in order; rsp_data A0,B1,C2,D3 with tags 0001,0010,0100,1000 on consecutive cycles.
- Requesters 1 and 3 valid continuously (addr 4 and 7) -> alternate 1,3,1,3; responses E4,34,E4,34; requester 3 never waits more than 1 cycle.
- en=0 with req_valid=1111 for 3 cycles -> req_ready=0, no rsp_valid, grant_cnt unchanged. en=1 -> grant resumes from ptr+1.
- rst_n pulsed low the cycle after a grant -> rsp_valid=0 immediately, grant_cnt=0; first post-reset grant goes to the lowest valid index.
- Preload grant_cnt path by 65536 grants -> count wraps to 0 with no other side effect.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared defaults for the ROM round-robin arbiter slice.
package rom_arb_pkg;
  localparam int unsigned NREQ_DEF    = 4;
  localparam int unsigned DEPTH_DEF   = 8;
  localparam int unsigned WIDTH_DEF   = 8;
  localparam int unsigned GRANT_CNT_W = 16;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module rr_pick #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      int unsigned j;
      j = (32'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one registered-read ROM among NREQ requesters;
// responses carry a one-hot tag and arrive exactly one cycle after acceptance.
module rom_rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*AW-1:0]     req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [AW-1:0]          rom_addr,
  input  logic [WIDTH-1:0]       rom_dout,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [GRANT_CNT_W-1:0] grant_cnt
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [NREQ-1:0]        gnt;
  logic [PW-1:0]          idx;
  logic                   any;
  logic                   fire;
  logic [AW-1:0]          sel_addr;
  logic [PW-1:0]          ptr_q;
  logic [AW-1:0]          addr_q;
  logic [NREQ-1:0]        rsp_valid_q;
  logic [GRANT_CNT_W-1:0] cnt_q;

  rr_pick #(.N(NREQ)) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  assign fire      = en & any;
  assign req_ready = en ? gnt : '0;

  always_comb begin
    sel_addr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel_addr = req_addr[i*AW +: AW];
    end
  end

  // Idle cycles replay the last granted address so the ROM port does not toggle.
  assign rom_addr  = fire ? sel_addr : addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rom_dout;
  assign grant_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= PW'(NREQ - 1);
      addr_q      <= '0;
      rsp_valid_q <= '0;
      cnt_q       <= '0;
    end else if (fire) begin
      ptr_q       <= idx;
      addr_q      <= sel_addr;
      rsp_valid_q <= gnt;
      cnt_q       <= cnt_q + GRANT_CNT_W'(1);
    end else begin
      rsp_valid_q <= '0;
    end
  end

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Self-checking bench for rom_rr_arbiter with an attached behavioural sync ROM.
module tb_rom_rr_arbiter;

  localparam int NR = 4;
  localparam int AWB = 3;
  localparam logic [7:0] ROM [8] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3,
                                     8'hE4, 8'hF5, 8'h16, 8'h34};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  req_valid;
  logic [11:0] req_addr;
  logic [3:0]  req_ready;
  logic [2:0]  rom_addr;
  logic [7:0]  rom_dout;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic [15:0] grant_cnt;

  int n_chk = 0;
  int n_fail = 0;

  int         m_ptr;
  int         m_cnt;
  logic [3:0] m_tag;
  logic [7:0] m_data;
  logic [2:0] m_last;

  logic [3:0]  s_rdy;
  logic [3:0]  s_rv;
  logic [7:0]  s_rd;
  logic [15:0] s_cnt;

  typedef struct {
    logic        r;
    logic        e;
    logic [3:0]  v;
    logic [11:0] a;
    logic [3:0]  rdy;
    logic [3:0]  rv;
    logic [7:0]  rd;
    int          cnt;
  } vec_t;

  vec_t tbl [18];

  always #5 clk = ~clk;

  always @(posedge clk) rom_dout <= ROM[rom_addr];

  rom_rr_arbiter #(.NREQ(4), .DEPTH(8), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .grant_cnt (grant_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Winner is the valid requester at the smallest forward distance past the pointer.
  function automatic int pick(input int ptr, input logic [3:0] v, input logic e);
    int best = -1;
    int bd = NR + 1;
    if (!e) return -1;
    for (int i = 0; i < NR; i++) begin
      if (v[i]) begin
        int d;
        d = (i - ptr - 1 + 2 * NR) % NR;
        if (d < bd) begin
          bd = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_ptr  = NR - 1;
    m_cnt  = 0;
    m_tag  = '0;
    m_data = '0;
    m_last = '0;
  endtask

  task automatic cycle(input logic r, input logic e, input logic [3:0] v, input logic [11:0] a);
    int g;
    logic [2:0] ga;
    rst_n = r;
    en = e;
    req_valid = v;
    req_addr = a;
    if (!r) model_reset();
    @(negedge clk);
    g = pick(m_ptr, v, e);
    ga = (g >= 0) ? a[g*AWB +: AWB] : m_last;
    s_rdy = req_ready;
    s_rv = rsp_valid;
    s_rd = rsp_data;
    s_cnt = grant_cnt;
    chk("req_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
    chk("rom_addr", 32'(rom_addr), 32'(ga));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_tag));
    if (m_tag != 0) chk("rsp_data", 32'(rsp_data), 32'(m_data));
    chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
    @(posedge clk);
    if (r && g >= 0) begin
      m_ptr  = g;
      m_cnt  = (m_cnt + 1) % 65536;
      m_tag  = 4'(1 << g);
      m_data = ROM[ga];
      m_last = ga;
    end else begin
      m_tag = '0;
    end
    #1;
  endtask

  initial begin
    logic [3:0]  rv;
    logic [11:0] ra;
    logic [2:0]  wa;

    tbl[0]  = '{1'b1, 1'b1, 4'b0001, {3'd0,3'd0,3'd0,3'd2}, 4'b0001, 4'b0000, 8'h00, 0};
    tbl[1]  = '{1'b1, 1'b1, 4'b0000, 12'd0,                  4'b0000, 4'b0001, 8'hC2, 1};
    tbl[2]  = '{1'b0, 1'b1, 4'b0000, 12'd0,                  4'b0000, 4'b0000, 8'h00, 0};
    tbl[3]  = '{1'b1, 1'b1, 4'b1111, {3'd3,3'd2,3'd1,3'd0}, 4'b0001, 4'b0000, 8'h00, 0};
    tbl[4]  = '{1'b1, 1'b1, 4'b1111, {3'd3,3'd2,3'd1,3'd0}, 4'b0010, 4'b0001, 8'hA0, 1};
    tbl[5]  = '{1'b1, 1'b1, 4'b1111, {3'd3,3'd2,3'd1,3'd0}, 4'b0100, 4'b0010, 8'hB1, 2};
    tbl[6]  = '{1'b1, 1'b1, 4'b1111, {3'd3,3'd2,3'd1,3'd0}, 4'b1000, 4'b0100, 8'hC2, 3};
    tbl[7]  = '{1'b1, 1'b1, 4'b1010, {3'd7,3'd0,3'd4,3'd0}, 4'b0010, 4'b1000, 8'hD3, 4};
    tbl[8]  = '{1'b1, 1'b1, 4'b1010, {3'd7,3'd0,3'd4,3'd0}, 4'b1000, 4'b0010, 8'hE4, 5};
    tbl[9]  = '{1'b1, 1'b1, 4'b1010, {3'd7,3'd0,3'd4,3'd0}, 4'b0010, 4'b1000, 8'h34, 6};
    tbl[10] = '{1'b1, 1'b1, 4'b1010, {3'd7,3'd0,3'd4,3'd0}, 4'b1000, 4'b0010, 8'hE4, 7};
    tbl[11] = '{1'b1, 1'b0, 4'b1111, {3'd3,3'd2,3'd1,3'd0}, 4'b0000, 4'b1000, 8'h34, 8};
    tbl[12] = '{1'b1, 1'b0, 4'b1111, {3'd3,3'd2,3'd1,3'd0}, 4'b0000, 4'b0000, 8'h00, 8};
    tbl[13] = '{1'b1, 1'b0, 4'b1111, {3'd3,3'd2,3'd1,3'd0}, 4'b0000, 4'b0000, 8'h00, 8};
    tbl[14] = '{1'b1, 1'b1, 4'b1111, {3'd3,3'd2,3'd1,3'd0}, 4'b0001, 4'b0000, 8'h00, 8};
    tbl[15] = '{1'b0, 1'b1, 4'b0000, 12'd0,                  4'b0000, 4'b0000, 8'h00, 0};
    tbl[16] = '{1'b1, 1'b1, 4'b1100, {3'd6,3'd5,3'd0,3'd0}, 4'b0100, 4'b0000, 8'h00, 0};
    tbl[17] = '{1'b1, 1'b1, 4'b0000, 12'd0,                  4'b0000, 4'b0100, 8'hF5, 1};

    model_reset();
    cycle(1'b0, 1'b0, 4'b0000, 12'd0);
    cycle(1'b0, 1'b1, 4'b0000, 12'd0);

    for (int t = 0; t < 18; t++) begin
      cycle(tbl[t].r, tbl[t].e, tbl[t].v, tbl[t].a);
      chk($sformatf("vec%0d ready", t), 32'(s_rdy), 32'(tbl[t].rdy));
      chk($sformatf("vec%0d rsp_valid", t), 32'(s_rv), 32'(tbl[t].rv));
      if (tbl[t].rv != 0) chk($sformatf("vec%0d rsp_data", t), 32'(s_rd), 32'(tbl[t].rd));
      chk($sformatf("vec%0d grant_cnt", t), 32'(s_cnt), 32'(tbl[t].cnt));
    end

    // Counter wrap: 65535 unchecked back-to-back grants, then the wrapping grant checked.
    cycle(1'b0, 1'b1, 4'b0000, 12'd0);
    ra = {3'd7, 3'd6, 3'd5, 3'd4};
    rst_n = 1'b1;
    en = 1'b1;
    req_valid = 4'b1111;
    req_addr = ra;
    repeat (65535) @(posedge clk);
    #1;
    m_cnt  = 65535;
    m_ptr  = (m_ptr + 65535) % NR;
    m_tag  = 4'(1 << m_ptr);
    wa     = ra[m_ptr*AWB +: AWB];
    m_data = ROM[wa];
    m_last = wa;
    cycle(1'b1, 1'b1, 4'b1111, ra);
    chk("wrap pre", 32'(s_cnt), 32'hFFFF);
    cycle(1'b1, 1'b1, 4'b0000, ra);
    chk("wrap post", 32'(s_cnt), 32'h0);
    chk("wrap rsp_valid", 32'(s_rv), 32'(1 << ((NR - 1 + 65536) % NR)));

    rv = 4'b0000;
    ra = 12'd0;
    for (int n = 0; n < 2000; n++) begin
      logic r;
      logic e;
      r = ($urandom_range(99) != 0);
      e = ($urandom_range(9) != 0);
      if ($urandom_range(3) == 0) rv = 4'($urandom);
      if ($urandom_range(1) == 0) ra = 12'($urandom);
      cycle(r, e, rv, ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
